// File: rtl/sample_packer_if.sv
// Sample strobe input and acknowledged byte stream output of the sample packer.
interface sample_packer_if #(
  parameter int SAMPLE_W = 48
);
  logic                sample_rdy;
  logic [SAMPLE_W-2:0] sample;
  logic                data_rdy;
  logic [7:0]          data;
  logic                data_ack;

  modport slave (
    input  sample_rdy,
    input  sample,
    output data_rdy,
    output data,
    input  data_ack
  );

  modport master (
    output sample_rdy,
    output sample,
    input  data_rdy,
    input  data,
    output data_ack
  );
endinterface

// File: rtl/sample_packer.sv
// Buffers flagged samples in a FIFO and serializes each word LSB byte first,
// with saturating accept/drop statistics.
module sample_packer #(
  parameter int SAMPLE_W = 48,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  sample_packer_if.slave             bus,
  input  logic                       counters_clr,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [CNT_W-1:0]           sample_count,
  output logic [CNT_W-1:0]           drop_count
);
  localparam int NB = SAMPLE_W / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(NB);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              r_state, w_state_nxt;
  logic [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [LW-1:0]       r_level;
  logic                r_lost;
  logic [SAMPLE_W-1:0] r_word;
  logic [BW-1:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0]    r_scnt, r_dcnt;
  logic                w_accept, w_drop, w_xfer, w_last, w_pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Occupancy is the registered level, so a same-cycle pop never frees a slot.
  assign w_accept = bus.sample_rdy && (r_level != LVL_FULL);
  assign w_drop   = bus.sample_rdy && (r_level == LVL_FULL);
  assign w_xfer   = (r_state == SEND) && bus.data_ack;
  assign w_last   = w_xfer && (r_idx == LAST_BYTE);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_level != '0) begin
          w_pop       = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_last) begin
          w_idx_nxt = '0;
          if (r_level != '0) w_pop = 1'b1;
          else w_state_nxt = IDLE;
        end else if (w_xfer) begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + LW'(w_accept) - LW'(w_pop);
      if (w_drop)        r_lost <= 1'b1;
      else if (w_accept) r_lost <= 1'b0;
    end
  end

  // Storage carries no reset; pointers and state decide what is valid.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wptr] <= {r_lost, bus.sample};
    if (w_pop)    r_word        <= r_mem[r_rptr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n || counters_clr) begin
      r_scnt <= '0;
      r_dcnt <= '0;
    end else begin
      if (w_accept) r_scnt <= sat_inc(r_scnt);
      if (w_drop)   r_dcnt <= sat_inc(r_dcnt);
    end
  end

  assign bus.data_rdy = (r_state == SEND);
  assign bus.data     = (r_state == SEND) ? r_word[8*r_idx +: 8] : 8'h00;
  assign fifo_level   = r_level;
  assign sample_count = r_scnt;
  assign drop_count   = r_dcnt;
endmodule

// File: tb/tb_sample_packer.sv
// Bench for sample_packer: directed scenarios plus randomized traffic against a queue model.
module tb_sample_packer;
  localparam int SAMPLE_W = 48;
  localparam int DEPTH    = 16;
  localparam int CNT_W    = 16;
  localparam int NB       = SAMPLE_W / 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             counters_clr = 1'b0;
  logic             clr4 = 1'b0;
  logic [4:0]       fifo_level, fifo_level4;
  logic [CNT_W-1:0] sample_count, drop_count;
  logic [3:0]       sample_count4, drop_count4;
  int               n_chk = 0;
  int               n_pass = 0;

  sample_packer_if #(.SAMPLE_W(SAMPLE_W)) bus ();
  sample_packer_if #(.SAMPLE_W(SAMPLE_W)) bus4 ();

  sample_packer #(.SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .counters_clr(counters_clr),
    .fifo_level(fifo_level), .sample_count(sample_count), .drop_count(drop_count)
  );

  sample_packer #(.SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4), .counters_clr(clr4),
    .fifo_level(fifo_level4), .sample_count(sample_count4), .drop_count(drop_count4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: buffer as a queue, serializer as current word plus byte index.
  logic [SAMPLE_W-1:0] mq[$];
  bit                  m_on = 0;
  bit                  m_send = 0;
  logic [SAMPLE_W-1:0] m_word = '0;
  int                  m_idx = 0;
  bit                  m_lost = 0;
  int                  m_scnt = 0, m_dcnt = 0, m_acc = 0;
  int                  words_out = 0, flags_set = 0;
  logic [7:0]          last_top = 8'h00;
  logic [SAMPLE_W-1:0] m_tmp;
  logic [7:0]          m_exp;
  bit                  m_xfer, m_last, m_pop;

  always @(negedge clk) begin
    if (m_on) begin
      m_tmp = m_word >> (8 * m_idx);
      m_exp = m_send ? m_tmp[7:0] : 8'h00;
      chk("mdl_data_rdy", bus.data_rdy, m_send);
      chk("mdl_data", bus.data, m_exp);
      chk("mdl_fifo_level", fifo_level, mq.size());
      chk("mdl_sample_count", sample_count, m_scnt);
      chk("mdl_drop_count", drop_count, m_dcnt);
      if (reset_n && m_send && bus.data_ack && m_idx == NB - 1) begin
        words_out++;
        last_top = bus.data;
        if (bus.data[7]) flags_set++;
      end
    end
    if (!reset_n) begin
      mq.delete();
      m_send = 0; m_idx = 0; m_lost = 0; m_scnt = 0; m_dcnt = 0; m_on = 1;
    end else if (m_on) begin
      m_xfer = m_send && bus.data_ack;
      m_last = m_xfer && (m_idx == NB - 1);
      m_pop  = (!m_send || m_last) && (mq.size() > 0);
      if (bus.sample_rdy) begin
        if (mq.size() < DEPTH) begin
          mq.push_back({m_lost, bus.sample});
          m_lost = 0;
          m_acc++;
          if (m_scnt < 2**CNT_W - 1) m_scnt++;
        end else begin
          m_lost = 1;
          if (m_dcnt < 2**CNT_W - 1) m_dcnt++;
        end
      end
      if (m_pop) begin
        m_word = mq.pop_front();
        m_idx  = 0;
        m_send = 1;
      end else if (m_last) begin
        m_send = 0;
        m_idx  = 0;
      end else if (m_xfer) begin
        m_idx++;
      end
      if (counters_clr) begin
        m_scnt = 0;
        m_dcnt = 0;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [SAMPLE_W-2:0] s);
    bus.sample     = s;
    bus.sample_rdy = 1'b1;
    cyc(1);
    bus.sample_rdy = 1'b0;
  endtask

  task automatic drain();
    bus.data_ack = 1'b1;
    for (int i = 0; i < 400 && (mq.size() != 0 || m_send); i++) cyc(1);
    cyc(1);
    chk("drain_idle", bus.data_rdy, 1'b0);
  endtask

  logic [7:0] exp31 [NB] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hED, 8'h7E};

  initial begin
    int wo, fs, acc0;
    bus.sample_rdy = 1'b0; bus.sample = '0; bus.data_ack = 1'b0;
    bus4.sample_rdy = 1'b0; bus4.sample = '0; bus4.data_ack = 1'b1;
    reset_n = 1'b0;
    cyc(2);
    strobe(47'h1234);
    chk("rst_data_rdy", bus.data_rdy, 1'b0);
    chk("rst_data", bus.data, 8'h00);
    chk("rst_level", fifo_level, 5'd0);
    chk("rst_scnt", sample_count, 16'd0);
    chk("rst_dcnt", drop_count, 16'd0);
    reset_n = 1'b1;
    cyc(3);
    chk("rst_sample_ignored", fifo_level, 5'd0);
    chk("rst_no_output", bus.data_rdy, 1'b0);

    // Single word, consumer always ready
    bus.data_ack = 1'b1;
    strobe(47'h7EEDDEADBEEF);
    chk("lat_rdy_e1", bus.data_rdy, 1'b0);
    chk("lat_level_e1", fifo_level, 5'd1);
    cyc(1);
    for (int i = 0; i < NB; i++) begin
      chk("w1_rdy", bus.data_rdy, 1'b1);
      chk($sformatf("w1_byte%0d", i), bus.data, exp31[i]);
      cyc(1);
    end
    chk("w1_done", bus.data_rdy, 1'b0);
    chk("w1_scnt", sample_count, 16'd1);

    // Fill with consumer stalled: one word in the serializer, 16 buffered, 4 dropped
    bus.data_ack = 1'b0;
    strobe(47'($urandom()));
    cyc(2);
    chk("fill_busy", bus.data_rdy, 1'b1);
    chk("fill_level0", fifo_level, 5'd0);
    for (int i = 0; i < 20; i++) strobe(47'({$urandom(), $urandom()}));
    cyc(1);
    chk("fill_level", fifo_level, 5'd16);
    chk("fill_drops", drop_count, 16'd4);
    chk("fill_scnt", sample_count, 16'd18);
    chk("fill_stall_byte0", bus.data_rdy, 1'b1);
    wo = words_out; fs = flags_set;
    drain();
    chk("fill_words_out", words_out - wo, 17);
    chk("fill_flags_clear", flags_set - fs, 0);

    // Lost flag marks only the first word after the drops
    strobe(47'($urandom()));
    drain();
    chk("lost_flag_set", last_top[7], 1'b1);
    strobe(47'($urandom()));
    drain();
    chk("lost_flag_clear", last_top[7], 1'b0);

    // Random throttling under heavy sample pressure
    wo = words_out; acc0 = m_acc;
    for (int i = 0; i < 800; i++) begin
      bus.sample     = 47'({$urandom(), $urandom()});
      bus.sample_rdy = ($urandom_range(0, 9) < 8);
      bus.data_ack   = ($urandom_range(0, 9) < 3);
      cyc(1);
    end
    bus.sample_rdy = 1'b0;
    drain();
    chk("rand_words_out", words_out - wo, m_acc - acc0);
    chk("rand_level", fifo_level, 5'd0);

    // Clear wins over a same-cycle accept
    counters_clr = 1'b1;
    strobe(47'h55);
    counters_clr = 1'b0;
    chk("clr_scnt", sample_count, 16'd0);
    chk("clr_dcnt", drop_count, 16'd0);
    chk("clr_keeps_buffer", fifo_level, 5'd1);
    drain();

    // Reset mid-word with three words buffered
    bus.data_ack = 1'b0;
    for (int i = 0; i < 4; i++) strobe(47'({$urandom(), $urandom()}));
    cyc(1);
    chk("mid_level", fifo_level, 5'd3);
    bus.data_ack = 1'b1;
    cyc(3);
    bus.data_ack = 1'b0;
    chk("mid_byte3", bus.data_rdy, 1'b1);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    chk("mid_rst_rdy", bus.data_rdy, 1'b0);
    chk("mid_rst_level", fifo_level, 5'd0);
    chk("mid_rst_scnt", sample_count, 16'd0);
    chk("mid_rst_dcnt", drop_count, 16'd0);
    wo = words_out;
    bus.data_ack = 1'b1;
    cyc(20);
    chk("mid_no_stale", words_out - wo, 0);
    strobe(47'h123456789AB);
    drain();
    chk("mid_post_word", words_out - wo, 1);

    // Narrow counters saturate
    for (int i = 0; i < 20; i++) begin
      bus4.sample     = 47'($urandom());
      bus4.sample_rdy = 1'b1;
      cyc(1);
      bus4.sample_rdy = 1'b0;
      cyc(1);
    end
    chk("sat_scnt", sample_count4, 4'd15);
    chk("sat_dcnt", drop_count4, 4'd0);
    clr4 = 1'b1;
    bus4.sample_rdy = 1'b1;
    cyc(1);
    clr4 = 1'b0;
    bus4.sample_rdy = 1'b0;
    chk("sat_clr", sample_count4, 4'd0);
    bus4.sample_rdy = 1'b1;
    cyc(1);
    bus4.sample_rdy = 1'b0;
    chk("sat_after_clr", sample_count4, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "timeout");
  end
endmodule
